// File: rtl/sda_gmem_pkg.sv
// Shared definitions for the gmem read arbiter: FSM encoding, AXI burst type
// and the ARSIZE encoding derived from the data width.
package sda_gmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AXI ARSIZE is log2 of the bytes per beat.
  function automatic logic [2:0] axi_arsize(input int data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == data_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/sda_rr_select.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping cyclically over NUM_PORTS.
module sda_rr_select
  import sda_gmem_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [$clog2(NUM_PORTS)-1:0] idx,
  output logic                         valid
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  always_comb begin
    idx = '0;
    // Scan farthest-first so the candidate nearest ptr is the last write and wins.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr) + k) % NUM_PORTS);
      if (req[cand]) idx = cand;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/sda_gmem_rd_arbiter.sv
// Round-robin arbiter sharing the single gmem AXI read master between
// NUM_PORTS requesters; one burst in flight, R beats steered to the grantee.
module sda_gmem_rd_arbiter
  import sda_gmem_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_PORTS*8-1:0]          req_arlen,
  input  logic [NUM_PORTS-1:0]            req_arvalid,
  output logic [NUM_PORTS-1:0]            req_arready,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic [1:0]                      req_rresp,
  output logic                            req_rlast,
  output logic [NUM_PORTS-1:0]            req_rvalid,
  input  logic [NUM_PORTS-1:0]            req_rready,
  output logic [ADDR_WIDTH-1:0]           m_axi_gmem_ARADDR,
  output logic [7:0]                      m_axi_gmem_ARLEN,
  output logic [2:0]                      m_axi_gmem_ARSIZE,
  output logic [1:0]                      m_axi_gmem_ARBURST,
  output logic                            m_axi_gmem_ARVALID,
  input  logic                            m_axi_gmem_ARREADY,
  input  logic [DATA_WIDTH-1:0]           m_axi_gmem_RDATA,
  input  logic [1:0]                      m_axi_gmem_RRESP,
  input  logic                            m_axi_gmem_RLAST,
  input  logic                            m_axi_gmem_RVALID,
  output logic                            m_axi_gmem_RREADY,
  output logic                            busy,
  output logic                            burst_err,
  output state_t                          state_dbg
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  // Handshakes: a transfer happens on a clock edge where valid && ready;
  // valid never waits on ready, and once raised it holds with stable
  // payload until the transfer. ARREADY/RREADY pass straight through the
  // grant mux, so the arbiter adds no cycle to either handshake.

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       exp_len_q, exp_len_d;
  logic             burst_err_q, burst_err_d;
  logic             len_mismatch;

  sda_rr_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_select (
    .req  (req_arvalid),
    .ptr  (rr_ptr_q),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

  assign m_axi_gmem_ARADDR  = req_araddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axi_gmem_ARLEN   = req_arlen[int'(grant_q)*8 +: 8];
  assign m_axi_gmem_ARSIZE  = axi_arsize(DATA_WIDTH);
  assign m_axi_gmem_ARBURST = AXI_BURST_INCR;

  assign req_rdata = m_axi_gmem_RDATA;
  assign req_rresp = m_axi_gmem_RRESP;
  assign req_rlast = m_axi_gmem_RLAST;

  assign busy      = (state_q != ST_IDLE);
  assign burst_err = burst_err_q;
  assign state_dbg = state_q;

  // RLAST must land exactly on the beat numbered ARLEN, never earlier or later.
  assign len_mismatch = m_axi_gmem_RLAST ? (beat_cnt_q != exp_len_q)
                                         : (beat_cnt_q == exp_len_q);

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    rr_ptr_d           = rr_ptr_q;
    beat_cnt_d         = beat_cnt_q;
    exp_len_d          = exp_len_q;
    burst_err_d        = burst_err_q;
    req_arready        = '0;
    req_rvalid         = '0;
    m_axi_gmem_ARVALID = 1'b0;
    m_axi_gmem_RREADY  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_d = sel_idx;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        m_axi_gmem_ARVALID   = 1'b1;
        req_arready[grant_q] = m_axi_gmem_ARREADY;
        if (m_axi_gmem_ARREADY) begin
          beat_cnt_d = '0;
          exp_len_d  = m_axi_gmem_ARLEN;
          rr_ptr_d   = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        req_rvalid[grant_q] = m_axi_gmem_RVALID;
        m_axi_gmem_RREADY   = req_rready[grant_q];
        if (m_axi_gmem_RVALID && req_rready[grant_q]) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (len_mismatch) burst_err_d = 1'b1;
          if (m_axi_gmem_RLAST) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      exp_len_q   <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_len_q   <= exp_len_d;
      burst_err_q <= burst_err_d;
    end
  end

endmodule
